// File: rtl/row_bank_sequencer.sv
// Row bank sequencer: loads 4 rows into banks feeding a 4:1 mux, then steps sel one row per handshake.
// Optional ROW_SEQ_REVERSE_EN: drain banks in descending order (3..0) instead of ascending.
module row_bank_sequencer #(
    parameter int num_bits = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [num_bits-1:0] in_data,
    output logic                in_ready,
    output logic [num_bits-1:0] bank0,
    output logic [num_bits-1:0] bank1,
    output logic [num_bits-1:0] bank2,
    output logic [num_bits-1:0] bank3,
    output logic [1:0]          sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_done
);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

`ifdef ROW_SEQ_REVERSE_EN
    localparam logic [1:0] FIRST_SEL = 2'd3;
    localparam logic [1:0] LAST_SEL  = 2'd0;
`else
    localparam logic [1:0] FIRST_SEL = 2'd0;
    localparam logic [1:0] LAST_SEL  = 2'd3;
`endif

    state_t              state, state_nx;
    logic [1:0]          wr_ptr, wr_ptr_nx;
    logic [1:0]          sel_nx;
    logic                in_ready_nx, out_valid_nx, frame_done_nx;
    logic                bank_we;
    logic [num_bits-1:0] banks [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            wr_ptr     <= 2'd0;
            sel        <= 2'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            sel        <= sel_nx;
            in_ready   <= in_ready_nx;
            out_valid  <= out_valid_nx;
            frame_done <= frame_done_nx;
        end
    end

    // flush outranks every handshake; a row presented alongside it is dropped
    always_comb begin
        state_nx      = state;
        wr_ptr_nx     = wr_ptr;
        sel_nx        = sel;
        in_ready_nx   = in_ready;
        out_valid_nx  = out_valid;
        frame_done_nx = 1'b0;
        bank_we       = 1'b0;
        if (flush) begin
            state_nx     = FILL;
            wr_ptr_nx    = 2'd0;
            sel_nx       = 2'd0;
            out_valid_nx = 1'b0;
            in_ready_nx  = 1'b1;
        end else begin
            case (state)
                FILL: begin
                    in_ready_nx  = 1'b1;
                    out_valid_nx = 1'b0;
                    if (in_valid && in_ready) begin
                        bank_we   = 1'b1;
                        wr_ptr_nx = wr_ptr + 2'd1;
                        if (wr_ptr == 2'd3) begin
                            state_nx     = DRAIN;
                            in_ready_nx  = 1'b0;
                            out_valid_nx = 1'b1;
                            sel_nx       = FIRST_SEL;
                        end
                    end
                end
                DRAIN: begin
                    in_ready_nx = 1'b0;
                    if (out_ready) begin
                        if (sel == LAST_SEL) begin
                            state_nx      = FILL;
                            sel_nx        = 2'd0;
                            out_valid_nx  = 1'b0;
                            in_ready_nx   = 1'b1;
                            frame_done_nx = 1'b1;
                        end else begin
`ifdef ROW_SEQ_REVERSE_EN
                            sel_nx = sel - 2'd1;
`else
                            sel_nx = sel + 2'd1;
`endif
                        end
                    end
                end
                default: begin
                    state_nx = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) banks[i] <= '0;
        end else if (bank_we) begin
            banks[wr_ptr] <= in_data;
        end
    end

    assign bank0 = banks[0];
    assign bank1 = banks[1];
    assign bank2 = banks[2];
    assign bank3 = banks[3];

endmodule
